// File: rtl/reg_writeback_queue_pkg.sv
// Shared writeback types: register index/data widths and the queue entry.
// Used by the register file, hazard unit and writeback queue.
package reg_writeback_queue_pkg;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;

  localparam logic [ADDR_W-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } wbEntry_t;

endpackage

// File: rtl/reg_writeback_queue_wb_fifo.sv
// Generic DEPTH-entry FIFO, 2-wide enqueue (A before B), 1-wide dequeue.
// The raw entry array and read pointer are exposed for associative search.
module wb_fifo #(
  parameter type T     = logic [7:0],
  parameter int  DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       enqA,
  input  T                           dataA,
  input  logic                       enqB,
  input  T                           dataB,
  input  logic                       deq,
  output T                           head,
  output T                           entries [DEPTH],
  output logic [$clog2(DEPTH)-1:0]   rdPtr,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  T mem [DEPTH];

  logic [PW-1:0] wrPtr;
  logic [PW-1:0] wrPtrB;

  assign wrPtrB = enqA ? wrPtr + PW'(1) : wrPtr;

  // Storage carries no reset; validity is tracked by count alone.
  always_ff @(posedge clk) begin
    if (enqA) mem[wrPtr] <= dataA;
    if (enqB) mem[wrPtrB] <= dataB;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      wrPtr <= wrPtr + PW'(enqA) + PW'(enqB);
      rdPtr <= rdPtr + PW'(deq);
      count <= count + CW'(enqA) + CW'(enqB) - CW'(deq);
    end
  end

  assign head    = mem[rdPtr];
  assign entries = mem;

endmodule

// File: rtl/reg_writeback_queue.sv
// Writeback queue feeding the register file write port.
// Define WB_FORWARD_EN to build the pending-write forwarding lookup.
module reg_writeback_queue
  import reg_writeback_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       AluValid,
  input  logic [ADDR_W-1:0]          AluReg,
  input  logic [DATA_W-1:0]          AluData,
  output logic                       AluReady,
  input  logic                       MemValid,
  input  logic [ADDR_W-1:0]          MemReg,
  input  logic [DATA_W-1:0]          MemData,
  output logic                       MemReady,
  output logic                       RegWrite,
  output logic [ADDR_W-1:0]          WriteRegister,
  output logic [DATA_W-1:0]          WriteData,
  input  logic [ADDR_W-1:0]          LookupReg,
  output logic                       FwdHit,
  output logic [DATA_W-1:0]          FwdData,
  output logic [$clog2(DEPTH):0]     Count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  wbEntry_t      head;
  wbEntry_t      lastOut;
  wbEntry_t      memEnt;
  wbEntry_t      aluEnt;
  wbEntry_t      entries [DEPTH];
  logic [PW-1:0] rdPtr;
  logic [CW-1:0] count;
  logic          memEnq;
  logic          aluEnq;

  // Load keeps the last free slot; ALU needs two when both are valid.
  assign MemReady = rst_n && (count <= CW'(DEPTH - 1));
  assign AluReady = rst_n && (MemValid ? (count <= CW'(DEPTH - 2))
                                       : (count <= CW'(DEPTH - 1)));

  assign memEnq = MemValid && MemReady && (MemReg != REG_ZERO);
  assign aluEnq = AluValid && AluReady && (AluReg != REG_ZERO);

  assign memEnt = '{rd: MemReg, data: MemData};
  assign aluEnt = '{rd: AluReg, data: AluData};

  wb_fifo #(
    .T     (wbEntry_t),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .enqA    (memEnq),
    .dataA   (memEnt),
    .enqB    (aluEnq),
    .dataB   (aluEnt),
    .deq     (RegWrite),
    .head    (head),
    .entries (entries),
    .rdPtr   (rdPtr),
    .count   (count)
  );

  assign RegWrite = (count != '0);
  assign Count    = count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lastOut <= '0;
    else if (RegWrite) lastOut <= head;
  end

  assign WriteRegister = RegWrite ? head.rd   : lastOut.rd;
  assign WriteData     = RegWrite ? head.data : lastOut.data;

`ifdef WB_FORWARD_EN
  // Walk oldest to youngest so the youngest match wins.
  always_comb begin
    FwdHit  = 1'b0;
    FwdData = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if ((CW'(k) < count) && (LookupReg != REG_ZERO) &&
          (entries[rdPtr + PW'(k)].rd == LookupReg)) begin
        FwdHit  = 1'b1;
        FwdData = entries[rdPtr + PW'(k)].data;
      end
    end
  end
`else
  logic unusedFwd;

  always_comb begin
    unusedFwd = ^{LookupReg, rdPtr};
    for (int k = 0; k < DEPTH; k++)
      unusedFwd = unusedFwd ^ (^entries[k]);
  end

  assign FwdHit  = 1'b0;
  assign FwdData = '0;
`endif

endmodule
